// File: rtl/ddr_wr_burst_packer_pkg.sv
// Shared constants for the DDR write burst packer: FSM encodings and burst sizing.
package ddr_wr_burst_packer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int CMD_LEN_W = 8;

  // Bytes covered by one burst of burst_len words, each ww bits wide.
  function automatic int burst_bytes(input int burst_len, input int ww);
    return (burst_len * ww) / 8;
  endfunction

endpackage

// File: rtl/ddr_wr_burst_packer_fifo.sv
// First-word-fall-through synchronous FIFO holding packed DDR words.
// dout always shows the head entry; a push into a full FIFO is taken only
// when a pop happens on the same edge.
module ddr_wr_burst_packer_fifo #(
  parameter int W  = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ddr_wr_burst_packer.sv
// Packs PACK narrow samples into DDR-width words, buffers them in a FIFO and
// issues fixed-length write bursts over a circular address range.
// Handshakes: a command or beat transfers on a rising edge where its valid and
// ready are both high; valid never waits for ready, and address/data stay
// stable while valid is high and ready is low.
module ddr_wr_burst_packer
  import ddr_wr_burst_packer_pkg::*;
#(
  parameter int                 DW        = 16,
  parameter int                 PACK      = 4,
  parameter int                 BURST_LEN = 8,
  parameter int                 FIFO_AW   = 5,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0]  ADDR_SPAN = ADDR_W'(32'h0010_0000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         DataIn,
  input  logic                  DataInValid,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [CMD_LEN_W-1:0]  cmd_len,
  output logic [DW*PACK-1:0]    wr_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic                  wr_last,
  input  logic                  clr_status,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic [31:0]           burst_cnt,
  output logic [1:0]            dbg_state
);

  localparam int WW          = DW * PACK;
  localparam int PCW         = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int BCW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_BYTES = burst_bytes(BURST_LEN, WW);
  localparam logic [ADDR_W:0] ADDR_END = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

  logic [PCW-1:0]         pack_cnt;
  logic [(PACK-1)*DW-1:0] hold;
  logic                   push_req;
  logic                   push;
  logic                   drop;
  logic [WW-1:0]          push_word;
  logic [FIFO_AW:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [1:0]             state;
  logic [BCW-1:0]         beat_cnt;
  logic [ADDR_W:0]        addr_sum;
  logic [ADDR_W-1:0]      next_addr;

  // The PACK-th sample completes a word and is pushed on the same edge.
  assign push_req  = DataInValid && (pack_cnt == PCW'(PACK-1));
  assign push_word = {DataIn, hold};
  assign drop      = push_req && fifo_full && !pop;
  assign push      = push_req && !drop;

  assign cmd_valid = (state == ST_CMD);
  assign wr_valid  = (state == ST_DATA);
  assign wr_last   = wr_valid && (beat_cnt == BCW'(BURST_LEN-1));
  assign cmd_len   = CMD_LEN_W'(BURST_LEN-1);
  assign pop       = wr_valid && wr_ready && !fifo_empty;
  assign dbg_state = state;

  assign addr_sum  = {1'b0, cmd_addr} + (ADDR_W+1)'(BURST_BYTES);
  assign next_addr = (addr_sum >= ADDR_END) ? BASE_ADDR : addr_sum[ADDR_W-1:0];

  ddr_wr_burst_packer_fifo #(
    .W  (WW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (wr_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sample packer: fills slots LSB-first; a partial word is only ever held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_cnt <= '0;
      hold     <= '0;
    end else if (DataInValid) begin
      if (push_req) begin
        pack_cnt <= '0;
      end else begin
        hold[int'(pack_cnt)*DW +: DW] <= DataIn;
        pack_cnt <= pack_cnt + 1'b1;
      end
    end
  end

  // Burst FSM: start only once a full burst is buffered, so beats never starve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (fifo_count >= (FIFO_AW+1)'(BURST_LEN)) state <= ST_CMD;
        ST_CMD:  if (cmd_ready) state <= ST_DATA;
        ST_DATA: begin
          if (pop) begin
            if (wr_last) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address generator and burst counter advance on the accepted last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_addr  <= BASE_ADDR;
      burst_cnt <= '0;
    end else if (pop && wr_last) begin
      cmd_addr  <= next_addr;
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Drop status: a drop on the same edge as a clear still registers itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_status)                drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_status) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
